// File: rtl/sig_sync_bank.sv
// Multi-channel asynchronous-input synchroniser bank: per-channel sync chain,
// programmable glitch filter, edge-mode pulse output and sticky W1C event flag.
module sig_sync_bank #(
  parameter int                CH_NUM      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILT_W      = 4,
  parameter logic [CH_NUM-1:0] RST_VAL     = {CH_NUM{1'b0}}
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [CH_NUM-1:0]   async_sig,
  input  logic [2*CH_NUM-1:0] mode_cfg,
  input  logic [FILT_W-1:0]   filt_len,
  input  logic [CH_NUM-1:0]   evt_clr,
  output logic [CH_NUM-1:0]   sync_level,
  output logic [CH_NUM-1:0]   sync_pulse,
  output logic [CH_NUM-1:0]   evt_flag
);
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [CH_NUM-1:0] sync_q [STAGES];
  logic [CH_NUM-1:0] sync_last;
  logic [CH_NUM-1:0] filt_q, filt_d;
  logic [CH_NUM-1:0] filt_dly_q;
  logic [FILT_W-1:0] cnt_q [CH_NUM];
  logic [FILT_W-1:0] cnt_d [CH_NUM];
  logic [CH_NUM-1:0] pulse_q, pulse_d;
  logic [CH_NUM-1:0] evt_q, evt_d;

  assign sync_last  = sync_q[STAGES-1];
  assign sync_level = filt_q;
  assign sync_pulse = pulse_q;
  assign evt_flag   = evt_q;

  // Plain flop chain, no logic between stages.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= async_sig;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // A change commits only after filt_len+1 consecutive disagreeing cycles; cnt
  // stays below filt_len before the commit, so the increment never wraps.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < CH_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_last[i] == filt_q[i]) begin
        cnt_d[i] = {FILT_W{1'b0}};
      end else if (cnt_q[i] >= filt_len) begin
        filt_d[i] = sync_last[i];
        cnt_d[i]  = {FILT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  // Edge selection per channel and sticky flag where set beats clear.
  always_comb begin
    pulse_d = {CH_NUM{1'b0}};
    for (int i = 0; i < CH_NUM; i++) begin
      case (mode_cfg[2*i +: 2])
        2'b01:   pulse_d[i] = filt_q[i] & ~filt_dly_q[i];
        2'b10:   pulse_d[i] = ~filt_q[i] & filt_dly_q[i];
        2'b11:   pulse_d[i] = filt_q[i] ^ filt_dly_q[i];
        default: pulse_d[i] = 1'b0;
      endcase
    end
    evt_d = pulse_q | (evt_q & ~evt_clr);
  end

  // Filter, edge-history and output state; f_d resets equal to f so release is silent.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      filt_q     <= RST_VAL;
      filt_dly_q <= RST_VAL;
      pulse_q    <= {CH_NUM{1'b0}};
      evt_q      <= {CH_NUM{1'b0}};
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= {FILT_W{1'b0}};
      end
    end else begin
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      pulse_q    <= pulse_d;
      evt_q      <= evt_d;
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sig_sync_bank.sv
// Bench for sig_sync_bank: vector table, hand-written corner sequences and a
// randomized run checked against a history-window reference model.
module tb_sig_sync_bank;
  localparam int         STG  = 2;
  localparam logic [3:0] RSTV = 4'b0001;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [3:0] async_sig = RSTV;
  logic [7:0] mode_cfg = 8'h55;
  logic [3:0] filt_len = 4'd0;
  logic [3:0] evt_clr = 4'b0000;
  logic [3:0] sync_level, sync_pulse, evt_flag;

  int n_cmp = 0;
  int n_err = 0;

  sig_sync_bank #(
    .CH_NUM(4), .SYNC_STAGES(STG), .FILT_W(4), .RST_VAL(RSTV)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .async_sig(async_sig),
    .mode_cfg(mode_cfg), .filt_len(filt_len), .evt_clr(evt_clr),
    .sync_level(sync_level), .sync_pulse(sync_pulse), .evt_flag(evt_flag)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: input history per edge; a level flips once the trailing
  // run of synchronised samples disagreeing with it exceeds filt_len.
  logic [3:0] in_h [0:1023];
  int         mn;
  logic [3:0] m_f, m_fd, m_pulse, m_evt;

  function automatic logic s_at(input int j, input int ch);
    if (j - STG >= 1) return in_h[j-STG][ch];
    return RSTV[ch];
  endfunction

  task automatic model_reset();
    mn = 0; m_f = RSTV; m_fd = RSTV; m_pulse = 4'b0000; m_evt = 4'b0000;
  endtask

  task automatic model_edge();
    logic [3:0] nf, np, ne;
    int run, j;
    if (mn < 1023) mn++;
    in_h[mn] = async_sig;
    for (int ch = 0; ch < 4; ch++) begin
      run = 0;
      j = mn;
      while (j >= 1 && run <= int'(filt_len) && s_at(j, ch) != m_f[ch]) begin
        run++;
        j--;
      end
      nf[ch] = (run > int'(filt_len)) ? ~m_f[ch] : m_f[ch];
      case (mode_cfg[2*ch +: 2])
        2'b01:   np[ch] = m_f[ch] & ~m_fd[ch];
        2'b10:   np[ch] = ~m_f[ch] & m_fd[ch];
        2'b11:   np[ch] = m_f[ch] ^ m_fd[ch];
        default: np[ch] = 1'b0;
      endcase
    end
    ne = m_pulse | (m_evt & ~evt_clr);
    m_fd = m_f; m_f = nf; m_pulse = np; m_evt = ne;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    chk("rst_level", sync_level, RSTV);
    chk("rst_pulse", sync_pulse, 4'b0000);
    chk("rst_evt", evt_flag, 4'b0000);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] pls;
    logic [3:0] evt;
  } vec_t;

  vec_t tbl [10];

  task automatic pulse_seq(input logic [1:0] m, input logic e4, input logic e9);
    async_sig = RSTV; filt_len = 4'd0; evt_clr = 4'b0000;
    mode_cfg = 8'h55;
    mode_cfg[5:4] = m;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      async_sig = (k <= 5) ? 4'b0101 : 4'b0001;
      step();
      chk($sformatf("mode%b_pulse2_k%0d", m, k), sync_pulse[2],
          ((k == 4) && e4) || ((k == 9) && e9));
      chk($sformatf("mode%b_level2_k%0d", m, k), sync_level[2], (k >= 3) && (k <= 7));
    end
  endtask

  initial begin
    tbl[0] = '{4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    tbl[2] = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
    tbl[3] = '{4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0000};
    tbl[4] = '{4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0010};
    tbl[5] = '{4'b0011, 4'b0010, 4'b0011, 4'b0000, 4'b0000};
    tbl[6] = '{4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
    tbl[7] = '{4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
    tbl[8] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    tbl[9] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    model_reset();
    #2;

    // Reset release with inputs equal to RST_VAL stays quiet.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("post_rst_level", sync_level, RSTV);
      chk("post_rst_pulse", sync_pulse, 4'b0000);
      chk("post_rst_evt", evt_flag, 4'b0000);
    end

    // Rise on ch1, filt_len 0, all channels in rise mode.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      async_sig = tbl[r].a;
      evt_clr = tbl[r].clr;
      step();
      chk($sformatf("tbl%0d_level", r), sync_level, tbl[r].lvl);
      chk($sformatf("tbl%0d_pulse", r), sync_pulse, tbl[r].pls);
      chk($sformatf("tbl%0d_evt", r), evt_flag, tbl[r].evt);
    end
    evt_clr = 4'b0000;

    // filt_len 3: a 3-cycle glitch is rejected, a held level commits on edge 6.
    filt_len = 4'd3;
    async_sig = RSTV;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      async_sig = (k <= 3) ? 4'b0011 : 4'b0001;
      step();
      chk($sformatf("glitch_level1_k%0d", k), sync_level[1], 1'b0);
      chk($sformatf("glitch_pulse1_k%0d", k), sync_pulse[1], 1'b0);
    end
    for (int k = 1; k <= 8; k++) begin
      async_sig = 4'b0011;
      step();
      chk($sformatf("held_level1_k%0d", k), sync_level[1], k >= 6);
    end

    pulse_seq(2'b11, 1'b1, 1'b1);
    pulse_seq(2'b10, 1'b0, 1'b1);
    pulse_seq(2'b00, 1'b0, 1'b0);

    // Clear coinciding with the pulse loses; clear one cycle later wins.
    async_sig = RSTV; mode_cfg = 8'h55; filt_len = 4'd0;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      async_sig = 4'b1001;
      evt_clr = (k >= 5) ? 4'b1000 : 4'b0000;
      step();
      if (k == 4) chk("clr_pulse3", sync_pulse[3], 1'b1);
      if (k == 5) chk("clr_same_cycle_evt3", evt_flag[3], 1'b1);
      if (k == 6) chk("clr_next_cycle_evt3", evt_flag[3], 1'b0);
    end
    evt_clr = 4'b0000;

    // Reset in the middle of a filter count (cnt 2 of filt_len 5).
    step(); step();
    chk("pre_mid_level", sync_level, 4'b1001);
    filt_len = 4'd5;
    async_sig = 4'b1011;
    repeat (4) step();
    chk("mid_count_level", sync_level, 4'b1001);
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("restart_level_k%0d", k), sync_level, (k >= 8) ? 4'b1011 : 4'b0001);
    end

    // Randomized run against the reference model.
    async_sig = RSTV; filt_len = 4'd0;
    mode_cfg = 8'($urandom);
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [3:0] tog;
      if (c % 100 == 0) filt_len = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) mode_cfg = 8'($urandom);
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 2) == 0);
      async_sig = async_sig ^ tog;
      evt_clr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      step();
      chk($sformatf("rnd%0d_level", c), sync_level, m_f);
      chk($sformatf("rnd%0d_pulse", c), sync_pulse, m_pulse);
      chk($sformatf("rnd%0d_evt", c), evt_flag, m_evt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
